// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forward-select encodings and the register-match rule.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register 0 is hardwired zero except on ARM, where it is a real register.
  function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b,
                                   input logic arm);
    return (a == b) && ((a != 5'd0) || arm);
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding select for one Execute source operand; Memory beats Writeback.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       arm,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && reg_hit(rd_m, rs, arm))
      fwd = FWD_MEM;
    else if (reg_write_w && reg_hit(rd_w, rs, arm))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and branch hazards,
// data-memory wait stalls with timeout, and a stall-cycle counter.
//   state   | meaning
//   RUN     | normal flow; load-use and branch hazards handled
//   MEMWAIT | data access outstanding; whole pipe frozen until MemAckM
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        TakenE,
  input  logic        armE,
  input  logic        MemReqM,
  input  logic        MemAckM,
  input  logic        ClrCnt,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemErr,
  output logic [15:0] StallCnt
);

  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic        mem_stall;
  logic        load_use;

  fwd_sel u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM),
    .reg_write_w(RegWriteW), .arm(armE), .fwd(ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM),
    .reg_write_w(RegWriteW), .arm(armE), .fwd(ForwardBE)
  );

  // The ack cycle itself releases the stall, so a wait costs exactly the unacked cycles.
  assign mem_stall = !MemAckM && ((state == MEMWAIT) || MemReqM);
  assign load_use  = ResultSrcE0 &&
                     (reg_hit(RdE, Rs1D, armE) || reg_hit(RdE, Rs2D, armE));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (TakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= 8'd0;
          if (MemReqM && !MemAckM)
            state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 8'd1;
          if (wait_cnt == WAIT_MAX - 8'd1)
            mem_err <= 1'b1;
          if (MemAckM)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
      if (ClrCnt)
        stall_cnt <= 16'd0;
      else if (StallF && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign MemErr   = mem_err;
  assign StallCnt = stall_cnt;

endmodule
